// File: rtl/nrzi_byte_rx.sv
// NRZI (toggle-encoded) serial receiver: hunts for a sync byte, reads a length byte,
// then delivers that many LSB-first payload bytes over a valid/ready handshake.
module nrzi_byte_rx #(
  parameter logic [7:0] SYNC_BYTE = 8'h7E
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_en,
  input  logic       line_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       data_last,
  output logic       sync_det,
  output logic       overrun
);

  typedef enum logic [1:0] {HUNT, LEN, DATA} state_t;

  state_t      state;
  logic        line_prev;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic [7:0]  byte_cnt;

  logic        d;
  logic [7:0]  shreg_nxt;
  logic        last_byte;
  logic        can_load;

  always_comb begin
    d         = line_in ^ line_prev;
    shreg_nxt = {d, shreg[7:1]};
    last_byte = (byte_cnt == 8'd1);
    // A completed byte may load if the slot is empty or is being emptied this cycle.
    can_load  = !data_valid || data_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= HUNT;
      line_prev  <= 1'b0;
      shreg      <= 8'd0;
      bit_cnt    <= 3'd0;
      byte_cnt   <= 8'd0;
      data_out   <= 8'd0;
      data_valid <= 1'b0;
      data_last  <= 1'b0;
      sync_det   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync_det <= 1'b0;
      overrun  <= 1'b0;
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
        data_last  <= 1'b0;
      end
      if (bit_en) begin
        line_prev <= line_in;
        shreg     <= shreg_nxt;
        case (state)
          HUNT: begin
            // Sliding match: any bit alignment can start a frame.
            if (shreg_nxt == SYNC_BYTE) begin
              sync_det <= 1'b1;
              bit_cnt  <= 3'd0;
              state    <= LEN;
            end
          end
          LEN: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (shreg_nxt == 8'd0) begin
                state <= HUNT;
              end else begin
                byte_cnt <= shreg_nxt;
                state    <= DATA;
              end
            end
          end
          DATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              // Framing advances even when the byte itself is dropped.
              byte_cnt <= byte_cnt - 8'd1;
              if (last_byte) state <= HUNT;
              if (can_load) begin
                data_out   <= shreg_nxt;
                data_valid <= 1'b1;
                data_last  <= last_byte;
              end else begin
                overrun <= 1'b1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nrzi_byte_rx.sv
// Bench for nrzi_byte_rx: directed scenarios plus random frame streams checked
// against a frame-level parser of the decoded bit stream.
module tb_nrzi_byte_rx;

  localparam logic [7:0] SYNC = 8'h7E;

  logic       clk = 1'b0;
  logic       reset, bit_en, line_in, data_ready;
  logic [7:0] data_out;
  logic       data_valid, data_last, sync_det, overrun;

  int errors = 0;
  int checks = 0;

  logic       line_lvl;
  logic [8:0] obs_q[$];
  int         sync_cnt = 0, ovr_cnt = 0, vld_cnt = 0, last_cnt = 0;
  int         b_obs, b_sync, b_ovr, b_vld, b_last;
  bit         stim[$];
  logic [8:0] exp_q[$];
  int         exp_sync;

  always #5 clk = ~clk;

  nrzi_byte_rx #(.SYNC_BYTE(SYNC)) dut (
    .clk(clk), .reset(reset), .bit_en(bit_en), .line_in(line_in),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .data_last(data_last), .sync_det(sync_det), .overrun(overrun)
  );

  always @(negedge clk) begin
    if (reset) begin
      if (data_valid && data_ready) obs_q.push_back({data_last, data_out});
      if (sync_det) sync_cnt++;
      if (overrun) ovr_cnt++;
      if (data_valid) vld_cnt++;
      if (data_valid && data_last) last_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mark();
    b_obs = obs_q.size(); b_sync = sync_cnt; b_ovr = ovr_cnt;
    b_vld = vld_cnt; b_last = last_cnt;
  endtask

  task automatic send_bit(input logic d);
    line_lvl = line_lvl ^ d;
    line_in  = line_lvl;
    bit_en   = 1'b1;
    tick();
    bit_en   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 0; k < 8; k++) send_bit(b[k]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      line_in = 1'($urandom);
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; bit_en = 1'b0; line_lvl = 1'b0; line_in = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  // Frame-level reference: slide an 8-bit window until it equals SYNC, then read
  // a length byte and that many payload bytes as whole octets.
  task automatic ref_parse();
    int i = 0;
    logic [7:0] win = 8'd0;
    logic [7:0] v;
    int n;
    exp_q.delete();
    exp_sync = 0;
    while (i < stim.size()) begin
      win = {stim[i], win[7:1]};
      i++;
      if (win == SYNC) begin
        exp_sync++;
        if (i + 8 > stim.size()) break;
        for (int k = 0; k < 8; k++) v[k] = stim[i + k];
        i += 8; win = v; n = v;
        for (int b = 0; b < n; b++) begin
          if (i + 8 > stim.size()) break;
          for (int k = 0; k < 8; k++) v[k] = stim[i + k];
          i += 8; win = v;
          exp_q.push_back({(b == n - 1), v});
        end
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int k = 0; k < 8; k++) stim.push_back(b[k]);
  endtask

  task automatic test_reset();
    reset = 1'b1; bit_en = 1'b0; line_in = 1'b0; data_ready = 1'b0; line_lvl = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({data_out, data_valid, data_last, sync_det, overrun} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 000", {data_out, data_valid, data_last, sync_det, overrun});
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (data_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release_valid: got %b required 0", data_valid);
    end
  endtask

  task automatic test_sync_detect();
    logic lv [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    data_ready = 1'b1;
    mark();
    for (int k = 0; k < 8; k++) begin
      line_lvl = lv[k]; line_in = lv[k]; bit_en = 1'b1;
      tick();
      bit_en = 1'b0;
      if (k == 6) begin
        checks++;
        if (sync_det !== 1'b0) begin errors++; $display("FAIL sync_early: got %b required 0", sync_det); end
      end
    end
    checks++;
    if (sync_det !== 1'b1) begin errors++; $display("FAIL sync_pulse: got %b required 1", sync_det); end
    tick();
    checks++;
    if (sync_det !== 1'b0) begin errors++; $display("FAIL sync_one_cycle: got %b required 0", sync_det); end
    send_byte(8'd1);
    send_byte(8'h5A);
    checks++;
    if ({data_valid, data_last, data_out} !== {2'b11, 8'h5A}) begin
      errors++; $display("FAIL sync_len_state: got v/l/d %b%b %h required 11 5a", data_valid, data_last, data_out);
    end
    tick();
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL sync_valid_clear: got %b required 0", data_valid); end
  endtask

  task automatic test_frame();
    data_ready = 1'b1;
    mark();
    send_byte(SYNC); send_byte(8'd2); send_byte(8'hA5);
    checks++;
    if ({data_valid, data_last, data_out} !== {2'b10, 8'hA5}) begin
      errors++; $display("FAIL frame_byte0: got v/l/d %b%b %h required 10 a5", data_valid, data_last, data_out);
    end
    send_byte(8'h3C);
    checks++;
    if ({data_valid, data_last, data_out} !== {2'b11, 8'h3C}) begin
      errors++; $display("FAIL frame_byte1: got v/l/d %b%b %h required 11 3c", data_valid, data_last, data_out);
    end
    tick();
    send_byte(8'h01); send_byte(8'h44);
    checks++;
    if (obs_q.size() - b_obs !== 2) begin
      errors++; $display("FAIL frame_count_hunt: got %0d required 2", obs_q.size() - b_obs);
    end else begin
      checks++;
      if (obs_q[b_obs] !== 9'h0A5 || obs_q[b_obs + 1] !== 9'h13C) begin
        errors++; $display("FAIL frame_bytes: got %h %h required 0a5 13c", obs_q[b_obs], obs_q[b_obs + 1]);
      end
    end
    send_byte(SYNC); send_byte(8'd1); send_byte(8'h99);
    tick();
    checks++;
    if (obs_q.size() - b_obs !== 3 || obs_q[obs_q.size() - 1] !== 9'h199) begin
      errors++; $display("FAIL frame_resync: got count %0d required 3 ending 199", obs_q.size() - b_obs);
    end
  endtask

  task automatic test_zero_length();
    data_ready = 1'b1;
    mark();
    send_byte(SYNC); send_byte(8'd0); send_byte(SYNC);
    tick();
    checks++;
    if (sync_cnt - b_sync !== 2) begin
      errors++; $display("FAIL zero_len_sync: got %0d required 2", sync_cnt - b_sync);
    end
    checks++;
    if (vld_cnt - b_vld !== 0) begin
      errors++; $display("FAIL zero_len_valid: got %0d valid cycles required 0", vld_cnt - b_vld);
    end
    send_byte(8'd0);
  endtask

  task automatic test_backpressure();
    data_ready = 1'b0;
    mark();
    send_byte(SYNC); send_byte(8'd3); send_byte(8'h11);
    checks++;
    if ({data_valid, data_last, data_out} !== {2'b10, 8'h11}) begin
      errors++; $display("FAIL bp_first: got v/l/d %b%b %h required 10 11", data_valid, data_last, data_out);
    end
    send_byte(8'h22);
    checks++;
    if ({overrun, data_valid, data_out} !== {2'b11, 8'h11}) begin
      errors++; $display("FAIL bp_overrun1: got o/v/d %b%b %h required 11 11", overrun, data_valid, data_out);
    end
    send_byte(8'h33);
    tick();
    checks++;
    if (ovr_cnt - b_ovr !== 2) begin
      errors++; $display("FAIL bp_overrun_count: got %0d required 2", ovr_cnt - b_ovr);
    end
    checks++;
    if (last_cnt - b_last !== 0 || data_out !== 8'h11 || data_valid !== 1'b1) begin
      errors++; $display("FAIL bp_hold: got last cycles %0d data %h valid %b required 0 11 1", last_cnt - b_last, data_out, data_valid);
    end
    data_ready = 1'b1;
    tick();
    checks++;
    if (data_valid !== 1'b0 || obs_q.size() - b_obs !== 1 || obs_q[obs_q.size() - 1] !== 9'h011) begin
      errors++; $display("FAIL bp_drain: got valid %b count %0d required 0 1", data_valid, obs_q.size() - b_obs);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b = 8'hF0;
    data_ready = 1'b0;
    mark();
    send_byte(SYNC); send_byte(8'd2); send_byte(8'h0F);
    for (int k = 0; k < 7; k++) send_bit(b[k]);
    data_ready = 1'b1;
    send_bit(b[7]);
    checks++;
    if ({data_valid, data_last, data_out, overrun} !== {2'b11, 8'hF0, 1'b0}) begin
      errors++; $display("FAIL b2b_load: got v/l/d/o %b%b %h %b required 11 f0 0", data_valid, data_last, data_out, overrun);
    end
    tick();
    checks++;
    if (obs_q.size() - b_obs !== 2 || ovr_cnt - b_ovr !== 0) begin
      errors++; $display("FAIL b2b_count: got %0d bytes %0d overruns required 2 0", obs_q.size() - b_obs, ovr_cnt - b_ovr);
    end else begin
      checks++;
      if (obs_q[b_obs] !== 9'h00F || obs_q[b_obs + 1] !== 9'h1F0) begin
        errors++; $display("FAIL b2b_bytes: got %h %h required 00f 1f0", obs_q[b_obs], obs_q[b_obs + 1]);
      end
    end
  endtask

  task automatic test_gapped();
    logic [7:0] s = SYNC;
    logic [7:0] p = 8'h81;
    data_ready = 1'b0;
    mark();
    for (int k = 0; k < 8; k++) begin
      send_bit(s[k]);
      if (k < 7) idle(3);
    end
    checks++;
    if (sync_det !== 1'b1) begin errors++; $display("FAIL gap_sync: got %b required 1", sync_det); end
    idle(1);
    checks++;
    if (sync_det !== 1'b0) begin errors++; $display("FAIL gap_sync_clear: got %b required 0", sync_det); end
    idle(2);
    for (int k = 0; k < 8; k++) begin send_bit(k == 0); idle(3); end
    for (int k = 0; k < 8; k++) begin
      send_bit(p[k]);
      if (k < 7) idle(3);
    end
    checks++;
    if ({data_valid, data_last, data_out} !== {2'b11, 8'h81}) begin
      errors++; $display("FAIL gap_payload: got v/l/d %b%b %h required 11 81", data_valid, data_last, data_out);
    end
    for (int c = 0; c < 3; c++) begin
      idle(1);
      checks++;
      if ({data_valid, data_last, data_out} !== {2'b11, 8'h81}) begin
        errors++; $display("FAIL gap_idle_hold: got v/l/d %b%b %h required 11 81", data_valid, data_last, data_out);
      end
    end
    data_ready = 1'b1;
    tick();
    checks++;
    if (obs_q.size() - b_obs !== 1 || sync_cnt - b_sync !== 1) begin
      errors++; $display("FAIL gap_counts: got %0d bytes %0d syncs required 1 1", obs_q.size() - b_obs, sync_cnt - b_sync);
    end
  endtask

  task automatic test_reset_mid_data();
    data_ready = 1'b0;
    send_byte(SYNC); send_byte(8'd2); send_byte(8'h66);
    for (int k = 0; k < 4; k++) send_bit(1'b1);
    reset = 1'b0;
    #1;
    checks++;
    if ({data_out, data_valid, data_last, sync_det, overrun} !== 12'd0) begin
      errors++; $display("FAIL mid_reset_outputs: got %h required 000", {data_out, data_valid, data_last, sync_det, overrun});
    end
    tick();
    line_lvl = 1'b0; line_in = 1'b0;
    reset = 1'b1;
    tick();
    data_ready = 1'b1;
    mark();
    send_byte(8'd1); send_byte(8'h55);
    tick();
    checks++;
    if (vld_cnt - b_vld !== 0 || sync_cnt - b_sync !== 0) begin
      errors++; $display("FAIL mid_reset_nosync: got %0d valid %0d syncs required 0 0", vld_cnt - b_vld, sync_cnt - b_sync);
    end
    send_byte(SYNC); send_byte(8'd1); send_byte(8'h55);
    tick();
    checks++;
    if (obs_q.size() - b_obs !== 1 || obs_q[obs_q.size() - 1] !== 9'h155) begin
      errors++; $display("FAIL mid_reset_resync: got count %0d required 1 of 155", obs_q.size() - b_obs);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      data_ready = 1'b1;
      mark();
      stim.delete();
      for (int f = 0; f < 6; f++) begin
        int junk = $urandom_range(0, 24);
        int n = $urandom_range(0, 4);
        for (int j = 0; j < junk; j++) stim.push_back(1'($urandom));
        push_byte(SYNC);
        push_byte(8'(n));
        for (int b = 0; b < n; b++) push_byte(8'($urandom));
      end
      ref_parse();
      foreach (stim[k]) send_bit(stim[k]);
      idle(2);
      checks++;
      if (sync_cnt - b_sync !== exp_sync) begin
        errors++; $display("FAIL rand_sync_count: got %0d required %0d", sync_cnt - b_sync, exp_sync);
      end
      checks++;
      if (ovr_cnt - b_ovr !== 0) begin
        errors++; $display("FAIL rand_overrun: got %0d required 0", ovr_cnt - b_ovr);
      end
      checks++;
      if (obs_q.size() - b_obs !== exp_q.size()) begin
        errors++; $display("FAIL rand_byte_count: got %0d required %0d", obs_q.size() - b_obs, exp_q.size());
      end else begin
        foreach (exp_q[k]) begin
          checks++;
          if (obs_q[b_obs + k] !== exp_q[k]) begin
            errors++; $display("FAIL rand_byte[%0d]: got %h required %h", k, obs_q[b_obs + k], exp_q[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sync_detect();
    test_frame();
    test_zero_length();
    test_backpressure();
    test_back_to_back();
    test_gapped();
    test_reset_mid_data();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
